// File: rtl/pc_pkg.sv
// +--------------------------------------------------------------------+
// | pc_pkg : shared widths and FSM encoding for the PC generator        |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package pc_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_t;

endpackage

`default_nettype wire

// File: rtl/redir_arbiter.sv
// +--------------------------------------------------------------------+
// | redir_arbiter : fixed-priority redirect select, index 0 wins        |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module redir_arbiter #(
  parameter int XLEN      = 32,
  parameter int NUM_REDIR = 3
) (
  input  logic [NUM_REDIR-1:0]           redir_valid,
  input  logic [NUM_REDIR-1:0][XLEN-1:0] redir_target,
  output logic                           sel_valid,
  output logic [XLEN-1:0]                sel_target
);

  // Scan from the highest index down so the lowest asserted index is the last writer.
  always_comb begin
    sel_valid  = 1'b0;
    sel_target = '0;
    for (int i = NUM_REDIR - 1; i >= 0; i--) begin
      if (redir_valid[i]) begin
        sel_valid  = 1'b1;
        sel_target = redir_target[i];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/pc_gen.sv
// +--------------------------------------------------------------------+
// | pc_gen : fetch PC generator with boot/run/halt FSM and redirects    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module pc_gen #(
  parameter int              XLEN         = pc_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int              NUM_REDIR    = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           stall_i,
  input  logic [NUM_REDIR-1:0]           redir_valid_i,
  input  logic [NUM_REDIR-1:0][XLEN-1:0] redir_target_i,
  input  logic                           halt_i,
  input  logic                           resume_i,
  input  logic                           fetch_ready_i,
  output logic                           fetch_valid_o,
  output logic [XLEN-1:0]                pc_o,
  output logic [XLEN-1:0]                pc_plus_4_o,
  output logic                           misalign_o,
  output logic [XLEN-1:0]                bad_addr_o,
  output logic [1:0]                     state_o
);

  import pc_pkg::*;

  pc_state_t       state;
  pc_state_t       state_next;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] pc_inc;
  logic            fetch_valid;
  logic            fetch_valid_next;
  logic            misalign;
  logic            misalign_next;
  logic [XLEN-1:0] bad_addr;
  logic [XLEN-1:0] bad_addr_next;
  logic            sel_valid;
  logic [XLEN-1:0] sel_target;
  logic            take_redir;

  redir_arbiter #(
    .XLEN      (XLEN),
    .NUM_REDIR (NUM_REDIR)
  ) u_redir_arbiter (
    .redir_valid  (redir_valid_i),
    .redir_target (redir_target_i),
    .sel_valid    (sel_valid),
    .sel_target   (sel_target)
  );

  assign pc_inc     = pc + XLEN'(INSTR_BYTES);
  assign take_redir = sel_valid && (state != BOOT);

  always_comb begin
    state_next = state;
    case (state)
      BOOT:    state_next = RUN;
      RUN:     if (halt_i) state_next = HALT;
      HALT:    if (resume_i && !halt_i) state_next = RUN;
      default: state_next = BOOT;
    endcase
  end

  // Valid trails the first RUN cycle after BOOT, then tracks RUN entry/exit exactly.
  assign fetch_valid_next = (state_next == RUN) && (state != BOOT);

  always_comb begin
    pc_next       = pc;
    misalign_next = 1'b0;
    bad_addr_next = bad_addr;
    if (take_redir) begin
      if (sel_target[1:0] != 2'b00) begin
        pc_next       = TRAP_VECTOR;
        misalign_next = 1'b1;
        bad_addr_next = sel_target;
      end else begin
        pc_next = sel_target;
      end
    end else if ((state == RUN) && fetch_valid && fetch_ready_i && !stall_i) begin
      pc_next = pc_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= RESET_VECTOR;
      fetch_valid <= 1'b0;
      misalign    <= 1'b0;
      bad_addr    <= '0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      fetch_valid <= fetch_valid_next;
      misalign    <= misalign_next;
      bad_addr    <= bad_addr_next;
    end
  end

  assign fetch_valid_o = fetch_valid;
  assign pc_o          = pc;
  assign pc_plus_4_o   = pc_inc;
  assign misalign_o    = misalign;
  assign bad_addr_o    = bad_addr;
  assign state_o       = state;

endmodule

`default_nettype wire

// File: tb/tb_pc_gen.sv
// +--------------------------------------------------------------------+
// | tb_pc_gen : directed self-checking bench for pc_gen                 |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_pc_gen;

  localparam int XLEN      = 32;
  localparam int NUM_REDIR = 3;

  logic                           clk;
  logic                           rst;
  logic                           stall_i;
  logic [NUM_REDIR-1:0]           redir_valid_i;
  logic [NUM_REDIR-1:0][XLEN-1:0] redir_target_i;
  logic                           halt_i;
  logic                           resume_i;
  logic                           fetch_ready_i;
  logic                           fetch_valid_o;
  logic [XLEN-1:0]                pc_o;
  logic [XLEN-1:0]                pc_plus_4_o;
  logic                           misalign_o;
  logic [XLEN-1:0]                bad_addr_o;
  logic [1:0]                     state_o;

  int n_assert = 0;
  int n_fail   = 0;

  pc_gen #(
    .XLEN         (XLEN),
    .RESET_VECTOR (32'h0000_0000),
    .TRAP_VECTOR  (32'h0000_0100),
    .NUM_REDIR    (NUM_REDIR)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_i        (stall_i),
    .redir_valid_i  (redir_valid_i),
    .redir_target_i (redir_target_i),
    .halt_i         (halt_i),
    .resume_i       (resume_i),
    .fetch_ready_i  (fetch_ready_i),
    .fetch_valid_o  (fetch_valid_o),
    .pc_o           (pc_o),
    .pc_plus_4_o    (pc_plus_4_o),
    .misalign_o     (misalign_o),
    .bad_addr_o     (bad_addr_o),
    .state_o        (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_redir();
    redir_valid_i  = '0;
    redir_target_i = '0;
  endtask

  initial begin
    rst = 1'b1; stall_i = 1'b0; halt_i = 1'b0; resume_i = 1'b0; fetch_ready_i = 1'b0;
    clr_redir();
    step(); step();
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_state", {30'd0, state_o}, 32'd0);
    chk("rst_valid", {31'd0, fetch_valid_o}, 32'd0);
    chk("rst_misalign", {31'd0, misalign_o}, 32'd0);
    chk("rst_bad", bad_addr_o, 32'h0);

    // Release reset with a redirect pending: it lands in BOOT and must be dropped.
    rst = 1'b0; fetch_ready_i = 1'b1;
    redir_valid_i = 3'b001; redir_target_i[0] = 32'h300;
    step();
    chk("boot_state", {30'd0, state_o}, 32'd1);
    chk("boot_valid", {31'd0, fetch_valid_o}, 32'd0);
    chk("boot_drop_pc", pc_o, 32'h0);
    clr_redir();
    step();
    chk("first_valid", {31'd0, fetch_valid_o}, 32'd1);
    chk("first_pc", pc_o, 32'h0);
    chk("pc_plus_4", pc_plus_4_o, 32'h4);
    step(); chk("seq_pc4", pc_o, 32'h4);
    step(); chk("seq_pc8", pc_o, 32'h8);

    fetch_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); chk("notready_hold", pc_o, 32'h8);
    end
    chk("notready_valid", {31'd0, fetch_valid_o}, 32'd1);
    fetch_ready_i = 1'b1; stall_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(); chk("stall_hold", pc_o, 32'h8);
    end
    stall_i = 1'b0;
    step(); chk("seq_pc12", pc_o, 32'hC);

    redir_valid_i = 3'b110;
    redir_target_i[0] = 32'h999; redir_target_i[1] = 32'h40; redir_target_i[2] = 32'h80;
    stall_i = 1'b1;
    step(); chk("redir_ch1_stall", pc_o, 32'h40);
    stall_i = 1'b0;
    redir_valid_i = 3'b011;
    redir_target_i[0] = 32'h60; redir_target_i[1] = 32'h44; redir_target_i[2] = 32'h0;
    step(); chk("redir_ch0_prio", pc_o, 32'h60);

    redir_valid_i = 3'b001; redir_target_i[0] = 32'h42; redir_target_i[1] = 32'h0;
    step();
    chk("mis_pc", pc_o, 32'h100);
    chk("mis_pulse", {31'd0, misalign_o}, 32'd1);
    chk("mis_bad", bad_addr_o, 32'h42);
    clr_redir();
    step();
    chk("mis_pulse_end", {31'd0, misalign_o}, 32'd0);
    chk("mis_bad_keep", bad_addr_o, 32'h42);
    chk("after_trap_pc", pc_o, 32'h104);

    halt_i = 1'b1; redir_valid_i = 3'b001; redir_target_i[0] = 32'h200;
    step();
    chk("halt_state", {30'd0, state_o}, 32'd2);
    chk("halt_valid", {31'd0, fetch_valid_o}, 32'd0);
    chk("halt_redir_pc", pc_o, 32'h200);
    clr_redir(); halt_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("halted_valid", {31'd0, fetch_valid_o}, 32'd0);
      chk("halted_pc", pc_o, 32'h200);
    end
    resume_i = 1'b1; halt_i = 1'b1;
    step(); chk("halt_wins", {30'd0, state_o}, 32'd2);
    halt_i = 1'b0;
    step();
    chk("resume_state", {30'd0, state_o}, 32'd1);
    chk("resume_valid", {31'd0, fetch_valid_o}, 32'd1);
    chk("resume_pc", pc_o, 32'h200);
    resume_i = 1'b0;
    step(); chk("resume_adv", pc_o, 32'h204);

    redir_valid_i = 3'b001; redir_target_i[0] = 32'hFFFF_FFFC;
    step();
    chk("wrap_pre", pc_o, 32'hFFFF_FFFC);
    chk("wrap_plus4", pc_plus_4_o, 32'h0);
    clr_redir();
    step(); chk("wrap_pc", pc_o, 32'h0);

    // Asynchronous reset arrives while a redirect and halt are pending.
    redir_valid_i = 3'b001; redir_target_i[0] = 32'h500; halt_i = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_pc", pc_o, 32'h0);
    chk("async_rst_state", {30'd0, state_o}, 32'd0);
    chk("async_rst_valid", {31'd0, fetch_valid_o}, 32'd0);
    step();
    chk("rst_hold_pc", pc_o, 32'h0);
    rst = 1'b0; halt_i = 1'b0;
    clr_redir();
    step();
    chk("reboot_state", {30'd0, state_o}, 32'd1);
    chk("reboot_valid0", {31'd0, fetch_valid_o}, 32'd0);
    step();
    chk("reboot_valid1", {31'd0, fetch_valid_o}, 32'd1);
    chk("reboot_pc", pc_o, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
